load_store_unit: RTL and testbench

//  Core-side initiator for data_mem. Takes one RV32I load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW),

---
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: issues one RV32I load or store at a time to a word-wide data
// memory, with byte-lane extraction for loads and read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata
);

    localparam logic [29:0] MAX_IDX = 30'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE, LD_RD, LD_CAP, ST_RD, ST_CAP, ST_WR, RESP
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        req_bad;
    logic        legal;
    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Classify the incoming request: illegal funct3, misalignment, or out of range
    always_comb begin
        legal = 1'b0;
        if (req_we) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
        end
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_bad    = !legal || misaligned || (req_addr[31:2] >= MAX_IDX);
    end

    // Lane selection and sign/zero extension of the returned memory word
    always_comb begin
        ld_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        load_val = mem_rdata;
        case (funct3_q)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = mem_rdata;
        endcase
    end

    // Merge sub-word store data into the addressed lane of the read word
    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Control FSM; outputs are registered and set on entry to each state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            funct3_q   <= 3'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 16'd0;
        end else begin
            resp_valid <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        funct3_q  <= req_funct3;
                        lane_q    <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (!req_we) begin
                            state     <= LD_RD;
                            mem_rd_en <= 1'b1;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            state     <= ST_WR;
                            mem_wr_en <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state     <= ST_RD;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                LD_RD: state <= LD_CAP;
                LD_CAP: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_val;
                end
                ST_RD: state <= ST_CAP;
                ST_CAP: begin
                    state     <= ST_WR;
                    mem_wr_en <= 1'b1;
                    mem_wdata <= merged;
                end
                ST_WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    resp_err  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a
// behavioural memory/extension model.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata = 32'd0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          resp_cnt = 0;
    int          overlap_cnt = 0;
    logic [31:0] last_addr = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata)
    );

    // Word-wide data memory with one-cycle registered read, plus activity counters
    always @(posedge clk) begin
        int idx;
        idx = int'(mem_addr >> 2);
        if (mem_rd_en && mem_wr_en) overlap_cnt++;
        if (mem_rd_en) begin
            rd_cnt++;
            last_addr = mem_addr;
            if (idx < MEM_WORDS) mem_rdata <= mem[idx];
        end
        if (mem_wr_en) begin
            wr_cnt++;
            last_addr = mem_addr;
            if (idx < MEM_WORDS) mem[idx] <= mem_wdata;
        end
        if (resp_valid) resp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: outcome of one request from the RV32I rules, updating ref_mem for stores
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd,
                         output int lat, output int nrd, output int nwr);
        int          sz;
        int          idx;
        int          sh;
        logic        legal;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
        sz    = 1 << f3[1:0];
        idx   = int'(addr >> 2);
        err   = !legal || ((int'(addr[1:0]) % sz) != 0) || ((addr >> 2) >= MEM_WORDS);
        rd    = 32'd0;
        nrd   = 0;
        nwr   = 0;
        lat   = 1;
        if (!err) begin
            w    = ref_mem[idx];
            sh   = int'(addr[1:0]) * 8;
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            if (!we) begin
                v = (w >> sh) & mask;
                if (!f3[2] && sz < 4 && v > (mask >> 1)) v = v | ~mask;
                rd  = v;
                lat = 3;
                nrd = 1;
            end else begin
                ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
                nwr = 1;
                nrd = (sz < 4) ? 1 : 0;
                lat = (sz < 4) ? 4 : 2;
            end
        end
    endtask

    // Issue one request, follow it to its response and compare against the model
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit keep,
                          output int waited, output logic [31:0] obs_rd);
        logic        eerr;
        logic [31:0] erd;
        int          elat, enrd, enwr, lat, busy_bad, rd0, wr0, rs0, idx;
        model(we, f3, addr, wd, eerr, erd, elat, enrd, enwr);
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_accept", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        rs0 = resp_cnt;
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 1;
        busy_bad = 0;
        while (!resp_valid && lat < 20) begin
            if (req_ready) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        obs_rd = resp_rdata;
        chk("latency", 32'(lat), 32'(elat));
        chk("resp_err", 32'(resp_err), 32'(eerr));
        chk("resp_rdata", resp_rdata, erd);
        chk("ready_low_busy", 32'(busy_bad), 32'd0);
        @(posedge clk);
        #1;
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("resp_count", 32'(resp_cnt - rs0), 32'd1);
        chk("rd_count", 32'(rd_cnt - rd0), 32'(enrd));
        chk("wr_count", 32'(wr_cnt - wr0), 32'(enwr));
        if (!eerr) begin
            chk("mem_addr", last_addr, {addr[31:2], 2'b00});
            idx = int'(addr >> 2);
            if (we) chk("mem_word", mem[idx], ref_mem[idx]);
        end
    endtask

    initial begin
        int          w;
        logic [31:0] r;
        logic [31:0] a;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;

        // Directed: word, byte and half stores with loads back
        do_req(1'b1, 3'b010, 32'h4, 32'h0000_0010, 1'b0, w, r);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, w, r);
        chk("lw_0x4", r, 32'h0000_0010);
        do_req(1'b1, 3'b000, 32'h5, 32'h0000_AB80, 1'b0, w, r);
        chk("sb_word", mem[1], 32'h0000_8010);
        do_req(1'b0, 3'b000, 32'h5, 32'h0, 1'b0, w, r);
        chk("lb_0x5", r, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h5, 32'h0, 1'b0, w, r);
        chk("lbu_0x5", r, 32'h0000_0080);
        do_req(1'b1, 3'b001, 32'h6, 32'h0000_BEEF, 1'b0, w, r);
        chk("sh_word", mem[1], 32'hBEEF_8010);
        do_req(1'b0, 3'b001, 32'h6, 32'h0, 1'b0, w, r);
        chk("lh_0x6", r, 32'hFFFF_BEEF);
        do_req(1'b0, 3'b101, 32'h6, 32'h0, 1'b0, w, r);
        chk("lhu_0x6", r, 32'h0000_BEEF);

        // Directed: error cases
        do_req(1'b0, 3'b010, 32'h3, 32'h0, 1'b0, w, r);
        do_req(1'b1, 3'b001, 32'h5, 32'h1234, 1'b0, w, r);
        do_req(1'b0, 3'b011, 32'h8, 32'h0, 1'b0, w, r);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, w, r);
        do_req(1'b1, 3'b100, 32'h8, 32'h0, 1'b0, w, r);

        // Reset in the middle of a sub-word store
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h4;
        req_wdata  = 32'hFF;
        w = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_err", 32'(resp_err), 32'd0);
        chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
        chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("abort_no_write", 32'(wr_cnt - w), 32'd0);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, w, r);
        chk("lw_after_abort", r, 32'hBEEF_8010);

        // Back-to-back loads with req_valid held high
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 3'(i % 2 == 0 ? 3'b010 : 3'b100), 32'(4 + i), 32'h0, 1'b1, w, r);
            if (i > 0) chk("b2b_no_gap", 32'(w), 32'd0);
        end
        req_valid = 1'b0;

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, 1'b0, w, r);
        end

        chk("rd_wr_exclusive", 32'(overlap_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
